// File: rtl/rle_decoder.sv
// rtl/rle_decoder.sv - JPEG coefficient run-length decoder
// Expands (run, level) pairs and EOB markers into fixed-length coefficient blocks.
module rle_decoder #(
  parameter int DATA_W  = 8,
  parameter int RUN_W   = 4,
  parameter int BLK_LEN = 64,
  parameter int IDX_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RUN_W-1:0]  in_run,
  input  logic [DATA_W-1:0] in_level,
  input  logic              in_eob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              err
);
  localparam int CW = ((RUN_W > IDX_W) ? RUN_W : IDX_W) + 1;
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(BLK_LEN - 1);

  typedef enum logic [1:0] {IDLE, ZEROS, LEVEL, FILL} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  pos;
  logic [RUN_W-1:0]  remaining;
  logic [DATA_W-1:0] level_q;
  logic              in_xfer, out_xfer, overrun;
  logic [CW-1:0]     room;

  assign in_ready  = (state == IDLE) & reset;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = (state != IDLE);
  assign out_xfer  = out_valid & out_ready;
  assign out_data  = (state == LEVEL) ? level_q : '0;
  assign out_idx   = pos;
  assign out_last  = (pos == LAST_POS);

  // A run must leave room for its level inside the current block.
  assign room    = CW'(BLK_LEN - 1) - CW'(pos);
  assign overrun = (CW'(in_run) > room);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          if (in_eob || overrun)   state_nxt = FILL;
          else if (in_run != '0)   state_nxt = ZEROS;
          else                     state_nxt = LEVEL;
        end
      end
      ZEROS: if (out_xfer && remaining == RUN_W'(1)) state_nxt = LEVEL;
      LEVEL: if (out_xfer) state_nxt = IDLE;
      FILL:  if (out_xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos       <= '0;
      remaining <= '0;
      level_q   <= '0;
      err       <= 1'b0;
    end else begin
      if (out_xfer) pos <= out_last ? '0 : pos + 1'b1;
      if (in_xfer) begin
        remaining <= in_run;
        level_q   <= in_level;
      end else if (state == ZEROS && out_xfer) begin
        remaining <= remaining - 1'b1;
      end
      if (in_xfer && !in_eob && overrun) err <= 1'b1;
    end
  end
endmodule

// File: doc/rle_decoder.md
Name: rle_decoder

Overview:
- Run-length decoder for the JPEG coefficient path; the inverse of the team's RLE encoder.
- Accepts (run, level) pairs or an end-of-block marker and expands them into a flat stream of BLK_LEN coefficients per block, zeros included.
- Feeds the inverse-zigzag/dequantiser stage.
- Valid/ready handshake on both sides; output is registered.

Parameters:
- DATA_W, 8, width of level and of output coefficient (two's complement, passed through unmodified)
- RUN_W, 4, width of run field (max run 15; run=15 with level=0 yields 16 zeros, i.e. JPEG ZRL)
- BLK_LEN, 64, coefficients per block
- IDX_W, 6, width of position counter; must satisfy 2^IDX_W >= BLK_LEN

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  pair/marker present
- in_ready  output  1  decoder can accept a pair this cycle
- in_run  input  RUN_W  number of zeros preceding level
- in_level  input  DATA_W  coefficient following the zeros
- in_eob  input  1  end-of-block marker; in_run/in_level ignored when 1
- out_valid  output  1  out_data holds a coefficient
- out_ready  input  1  downstream accepts coefficient
- out_data  output  DATA_W  expanded coefficient
- out_idx  output  IDX_W  position of out_data within block (0..BLK_LEN-1)
- out_last  output  1  out_data is position BLK_LEN-1
- err  output  1  sticky overrun flag

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (reset=0, takes effect immediately): state=IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, err=0, in_ready=0 while reset is low.
  - Any partial block is discarded; first block after reset starts at position 0.
- Accept: a pair transfers on in_valid & in_ready. in_ready = (state==IDLE) & reset released.
- Emit: a coefficient transfers on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data/out_idx/out_last are held stable.
  - out_valid never drops without a transfer.
- Position counter pos (IDX_W):
  - increments on every output transfer;
  - after the transfer at BLK_LEN-1 it wraps to 0;
  - out_idx = pos, out_last = (pos==BLK_LEN-1).
- States:
  - IDLE: out_valid=0, in_ready=1. On accept:
    - in_eob=1 -> FILL;
    - else if in_run > (BLK_LEN-1-pos) -> set err, -> FILL (level dropped, remainder zero-filled);
    - else if in_run>0 -> ZEROS with remaining=in_run;
    - else -> LEVEL.
  - ZEROS: out_valid=1, out_data=0. Each transfer decrements remaining; transfer with remaining==1 -> LEVEL.
  - LEVEL: out_valid=1, out_data=latched level (a level of 0 is emitted as a literal 0). Transfer -> IDLE.
  - FILL: out_valid=1, out_data=0 until the transfer with out_last=1, then -> IDLE.
    - EOB at pos=0 emits a full block of BLK_LEN zeros.
- Timing:
  - Latency: pair accepted at cycle N -> first coefficient valid at N+1.
  - One bubble cycle in IDLE between pairs (in_ready high, out_valid low).
  - Throughput with out_ready=1: run+1 coefficients per run+2 cycles.
- Block boundary:
  - A non-EOB pair whose level lands exactly at BLK_LEN-1 completes the block with out_last=1 on the level.
  - No implicit EOB is needed after such a pair; the next pair starts at pos 0.
- err: set only by overrun; cleared only by reset.
- Output registers are driven only from state; there is no combinational in->out path.

Test Plan:
- Pairs (0,5),(2,-3),EOB with out_ready=1 -> out_data 5,0,0,-3 then 60 zeros; out_idx 0..63; out_last only at idx 63; err=0.
- Pair (15,0) then (0,7), EOB -> 16 zeros, 7 at idx 16, zeros to idx 63.
- EOB immediately after reset -> 64 zeros with out_idx 0..63, out_last at 63; next pair (0,9) -> 9 at idx 0.
- Drive 60 zeros' worth of pairs to pos=60, then (5,4) -> err=1; positions 60..63 emitted as 0, level 4 never emitted; err stays 1 into next block.
- Random out_ready toggling on pair (3,12) -> out_data/out_idx stable while stalled; exact sequence 0,0,0,12 with no drops or duplicates.
- Assert reset=0 mid-ZEROS (pos=10) -> out_valid=0 and out_idx=0 asynchronously; after release, EOB yields 64 zeros starting idx 0.
